param_alu: RTL and testbench

Parametrised second-generation register-bus ALU. Software loads operands and queues commands through a 32-bit register bus. An in-order executor drains a command queue, runs single-cycle logic/add ops or a configurable-depth pipelined multiplier, and publishes results and sticky status back to the register map. It sits on the same register bus as the existing TinyALU-class peripherals and replaces the pin-level A/B/op/start interface.

---
 rtl/param_alu_pkg.sv | 49 ++++
 rtl/param_alu_mult.sv | 50 +++++
 rtl/param_alu.sv | 234 +++++++++++++++++++++++
 tb/tb_param_alu.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_alu_pkg.sv
// -----------------------------------------------------------------------------
// param_alu_pkg
// Shared definitions for the register-bus ALU: operation codes, register
// offsets within the block, STATUS bit positions, executor state encodings
// and a byte-lane merge helper used for masked register writes.
// No ports (package).
// -----------------------------------------------------------------------------
package param_alu_pkg;

   // Operation codes carried in CMD[2:0]. Codes 101..111 are illegal.
   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_ADD = 3'b001,
      OP_AND = 3'b010,
      OP_XOR = 3'b011,
      OP_MUL = 3'b100
   } op_e;

   // Register offsets relative to the block base address.
   localparam logic [31:0] REG_SRC    = 32'h0;
   localparam logic [31:0] REG_CMD    = 32'h4;
   localparam logic [31:0] REG_RESULT = 32'h8;
   localparam logic [31:0] REG_STATUS = 32'hC;

   // CMD and STATUS field positions.
   localparam int CMD_GO_BIT   = 8;
   localparam int ST_BUSY      = 0;
   localparam int ST_DONE      = 1;
   localparam int ST_OVF       = 2;
   localparam int ST_ILL       = 3;
   localparam int ST_LEVEL_LSB = 8;
   localparam int ST_COUNT_LSB = 16;

   // Executor state encodings.
   localparam logic [0:0] FSM_IDLE     = 1'b0;
   localparam logic [0:0] FSM_MUL_WAIT = 1'b1;

   // Replace only the byte lanes enabled in mask.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  mask);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = mask[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/param_alu_mult.sv
// -----------------------------------------------------------------------------
// param_alu_mult
// STAGES-deep registered multiplier pipeline. The product is formed into the
// first stage register and shifted through the rest, with a valid bit
// travelling alongside, so out_valid rises STAGES edges after in_valid.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   in_valid, a, b    operand launch
//   out_valid         product valid at the pipeline end
//   product           2*DATA_W-bit unsigned product
// -----------------------------------------------------------------------------
module param_alu_mult #(
   parameter int DATA_W = 8,
   parameter int STAGES = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  out_valid,
   output logic [2*DATA_W-1:0]   product
);

   logic [2*DATA_W-1:0] prod_q [STAGES];
   logic [STAGES-1:0]   vld_q;
   logic [2*DATA_W-1:0] prod_in;

   assign prod_in = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            prod_q[i] <= '0;
         end
      end else begin
         vld_q[0]  <= in_valid;
         prod_q[0] <= prod_in;
         for (int i = 1; i < STAGES; i++) begin
            vld_q[i]  <= vld_q[i-1];
            prod_q[i] <= prod_q[i-1];
         end
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign product   = prod_q[STAGES-1];

endmodule

// File: rtl/param_alu.sv
// -----------------------------------------------------------------------------
// param_alu
// Register-bus ALU. Software writes operands to SRC and queues commands via
// CMD (go bit). An in-order executor pops one command per cycle for the
// single-cycle ops, or launches the pipelined multiplier and waits for it.
// Results and sticky status are published in RESULT/STATUS.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   valid, read           bus request strobe and direction (1 = read)
//   addr, wdata, wmask    absolute byte address, write data, byte enables
//   rdata                 registered read data (holds between reads)
//   result                last completed result
//   done                  one-cycle pulse per completed op
// Handshake: the bus has no ready/stall; a request is taken on every edge
// where valid=1, writes take effect on that edge, and read data appears in
// rdata on that same edge (available the cycle after the request).
// -----------------------------------------------------------------------------
module param_alu
   import param_alu_pkg::*;
#(
   parameter int          DATA_W      = 8,
   parameter int          MULT_STAGES = 3,
   parameter int          QDEPTH      = 4,
   parameter logic [31:0] ADDR_OFFSET = 32'h0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid,
   input  logic                  read,
   input  logic [31:0]           addr,
   input  logic [31:0]           wdata,
   input  logic [3:0]            wmask,
   output logic [31:0]           rdata,
   output logic [2*DATA_W-1:0]   result,
   output logic                  done
);

   localparam int RES_W = 2 * DATA_W;
   localparam int AW    = $clog2(QDEPTH);
   localparam int PW    = AW + 1;   // extra bit tells full from empty at wrap

   localparam logic [15:0] LANE_MASK = 16'((32'd1 << DATA_W) - 32'd1);
   localparam logic [31:0] SRC_MASK  = {LANE_MASK, LANE_MASK};

   // Registers
   logic [31:0]       src_q;
   logic [2:0]        cmd_op_q;
   logic [0:0]        state_q;
   logic              done_sticky_q, ovf_q, ill_q;
   logic [15:0]       count_q;
   logic [RES_W-1:0]  result_q;
   logic              done_q;
   logic [31:0]       rdata_q;

   // Command queue
   logic [2:0]        q_op [QDEPTH];
   logic [DATA_W-1:0] q_a  [QDEPTH];
   logic [DATA_W-1:0] q_b  [QDEPTH];
   logic [PW-1:0]     wptr_q, rptr_q;
   logic [PW-1:0]     level;
   logic              empty, full;

   // Bus decode
   logic wr_en, rd_en;
   logic hit_src, hit_cmd, hit_result, hit_status;

   assign wr_en      = valid & ~read;
   assign rd_en      = valid & read;
   assign hit_src    = (addr == ADDR_OFFSET + REG_SRC);
   assign hit_cmd    = (addr == ADDR_OFFSET + REG_CMD);
   assign hit_result = (addr == ADDR_OFFSET + REG_RESULT);
   assign hit_status = (addr == ADDR_OFFSET + REG_STATUS);

   // Queue status
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign level = wptr_q - rptr_q;

   // Push path: the op comes from wdata when byte 0 is written, otherwise
   // from the stored CMD op field.
   logic       push_req, push_ok;
   logic [2:0] push_op;

   assign push_req = wr_en & hit_cmd & wmask[1] & wdata[CMD_GO_BIT];
   assign push_op  = wmask[0] ? wdata[2:0] : cmd_op_q;

   // Executor
   logic [2:0]        head_op;
   logic [DATA_W-1:0] head_a, head_b;
   logic              pop, single_op, illegal_op, mul_start;
   logic              complete_single, complete_mul, op_done;
   logic [RES_W-1:0]  alu_res;
   logic              mul_out_valid;
   logic [RES_W-1:0]  mul_product;

   assign head_op    = q_op[rptr_q[AW-1:0]];
   assign head_a     = q_a[rptr_q[AW-1:0]];
   assign head_b     = q_b[rptr_q[AW-1:0]];
   assign pop        = (state_q == FSM_IDLE) && !empty;
   assign single_op  = (head_op == OP_ADD) || (head_op == OP_AND) || (head_op == OP_XOR);
   assign illegal_op = head_op[2] && (head_op[1:0] != 2'b00);
   assign mul_start  = pop && (head_op == OP_MUL);

   // A same-cycle pop frees a slot, so a push into a full queue still lands.
   assign push_ok = push_req && (!full || pop);

   assign complete_single = pop && single_op;
   assign complete_mul    = (state_q == FSM_MUL_WAIT) && mul_out_valid;
   assign op_done         = complete_single || complete_mul;

   always_comb begin
      alu_res = '0;
      case (head_op)
         OP_ADD:  alu_res = {{DATA_W{1'b0}}, head_a} + {{DATA_W{1'b0}}, head_b};
         OP_AND:  alu_res = {{DATA_W{1'b0}}, head_a & head_b};
         OP_XOR:  alu_res = {{DATA_W{1'b0}}, head_a ^ head_b};
         default: alu_res = '0;
      endcase
   end

   param_alu_mult #(
      .DATA_W (DATA_W),
      .STAGES (MULT_STAGES)
   ) u_mult (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (mul_start),
      .a         (head_a),
      .b         (head_b),
      .out_valid (mul_out_valid),
      .product   (mul_product)
   );

   // STATUS W1C clears; a coincident set event wins.
   logic clr_done, clr_ovf, clr_ill;
   logic w1c_en;

   assign w1c_en   = wr_en & hit_status & wmask[0];
   assign clr_done = w1c_en & wdata[ST_DONE];
   assign clr_ovf  = w1c_en & wdata[ST_OVF];
   assign clr_ill  = w1c_en & wdata[ST_ILL];

   // Read mux
   logic        busy;
   logic [31:0] rd_mux;

   assign busy = !empty || (state_q != FSM_IDLE);

   always_comb begin
      rd_mux = '0;
      if (hit_src) begin
         rd_mux = src_q;
      end else if (hit_cmd) begin
         rd_mux[2:0] = cmd_op_q;
      end else if (hit_result) begin
         rd_mux[RES_W-1:0] = result_q;
      end else if (hit_status) begin
         rd_mux[ST_BUSY]                = busy;
         rd_mux[ST_DONE]                = done_sticky_q;
         rd_mux[ST_OVF]                 = ovf_q;
         rd_mux[ST_ILL]                 = ill_q;
         rd_mux[ST_LEVEL_LSB +: PW]     = level;
         rd_mux[ST_COUNT_LSB +: 16]     = count_q;
      end
   end

   // Queue storage needs no reset: entries are only visible between pointers.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         q_op[wptr_q[AW-1:0]] <= push_op;
         q_a[wptr_q[AW-1:0]]  <= src_q[DATA_W-1:0];
         q_b[wptr_q[AW-1:0]]  <= src_q[16 +: DATA_W];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_q         <= '0;
         cmd_op_q      <= '0;
         state_q       <= FSM_IDLE;
         done_sticky_q <= 1'b0;
         ovf_q         <= 1'b0;
         ill_q         <= 1'b0;
         count_q       <= '0;
         result_q      <= '0;
         done_q        <= 1'b0;
         rdata_q       <= '0;
         wptr_q        <= '0;
         rptr_q        <= '0;
      end else begin
         if (wr_en && hit_src) begin
            src_q <= merge_bytes(src_q, wdata, wmask) & SRC_MASK;
         end
         if (wr_en && hit_cmd && wmask[0]) begin
            cmd_op_q <= wdata[2:0];
         end
         if (rd_en) begin
            rdata_q <= rd_mux;
         end

         if (push_ok) begin
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 1'b1;
         end

         // Executor state and result publication
         if (mul_start) begin
            state_q <= FSM_MUL_WAIT;
         end else if (complete_mul) begin
            state_q <= FSM_IDLE;
         end
         if (complete_single) begin
            result_q <= alu_res;
         end else if (complete_mul) begin
            result_q <= mul_product;
         end
         done_q <= op_done;
         if (op_done) begin
            count_q <= count_q + 16'd1;
         end

         done_sticky_q <= (done_sticky_q & ~clr_done) | op_done;
         ovf_q         <= (ovf_q & ~clr_ovf) | (push_req & ~push_ok);
         ill_q         <= (ill_q & ~clr_ill) | (pop & illegal_op);
      end
   end

   assign rdata  = rdata_q;
   assign result = result_q;
   assign done   = done_q;

endmodule

// File: tb/tb_param_alu.sv
// -----------------------------------------------------------------------------
// tb_param_alu
// Directed self-checking bench for param_alu (DATA_W=8, MULT_STAGES=3,
// QDEPTH=4). Inputs are driven on the falling edge; outputs are sampled
// 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_param_alu;

   localparam logic [31:0] A_SRC    = 32'h0;
   localparam logic [31:0] A_CMD    = 32'h4;
   localparam logic [31:0] A_RESULT = 32'h8;
   localparam logic [31:0] A_STATUS = 32'hC;

   logic        clk;
   logic        reset;
   logic        valid;
   logic        read;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wmask;
   logic [31:0] rdata;
   logic [15:0] result;
   logic        done;

   int n_cmp;
   int n_fail;
   int done_seen;

   param_alu #(
      .DATA_W      (8),
      .MULT_STAGES (3),
      .QDEPTH      (4),
      .ADDR_OFFSET (32'h0)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .valid  (valid),
      .read   (read),
      .addr   (addr),
      .wdata  (wdata),
      .wmask  (wmask),
      .rdata  (rdata),
      .result (result),
      .done   (done)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count done pulses, sampled mid-cycle.
   initial done_seen = 0;
   always @(negedge clk) begin
      if (done === 1'b1) done_seen++;
   end

   // Driver tasks: each request occupies exactly one rising edge.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      @(negedge clk);
      valid = 1'b1; read = 1'b0; addr = a; wdata = d; wmask = m;
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      valid = 1'b1; read = 1'b1; addr = a; wdata = '0; wmask = '0;
      @(posedge clk);
      #1;
      valid = 1'b0; read = 1'b0;
      d = rdata;
   endtask

   task automatic test_reset();
      reset = 1'b1; valid = 1'b0; read = 1'b0; addr = '0; wdata = '0; wmask = '0;
      repeat (2) @(negedge clk);
      n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0); end
      n_cmp++; if (result !== 16'h0) begin n_fail++; $display("FAIL reset_result: got %h expected %h", result, 16'h0); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      reset = 1'b0;
      begin
         logic [31:0] d;
         bus_read(A_STATUS, d);
         n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h expected %h", d, 32'h0); end
      end
   endtask

   task automatic test_bus();
      logic [31:0] d;
      bus_write(A_SRC, 32'hFFFF_FFFF, 4'hF);
      bus_read(A_SRC, d);
      n_cmp++; if (d !== 32'h00FF_00FF) begin n_fail++; $display("FAIL src_unused_bits: got %h expected %h", d, 32'h00FF_00FF); end
      bus_write(A_SRC, 32'h1234_5678, 4'b0001);
      bus_read(A_SRC, d);
      n_cmp++; if (d !== 32'h00FF_0078) begin n_fail++; $display("FAIL src_wmask: got %h expected %h", d, 32'h00FF_0078); end
      bus_write(A_CMD, 32'h0000_0003, 4'hF);
      bus_read(A_CMD, d);
      n_cmp++; if (d !== 32'h0000_0003) begin n_fail++; $display("FAIL cmd_readback: got %h expected %h", d, 32'h3); end
      // rdata holds across an idle cycle
      @(negedge clk);
      n_cmp++; if (rdata !== 32'h0000_0003) begin n_fail++; $display("FAIL rdata_hold: got %h expected %h", rdata, 32'h3); end
      bus_write(32'h10, 32'hFFFF_FFFF, 4'hF);
      bus_read(32'h10, d);
      n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h expected %h", d, 32'h0); end
   endtask

   task automatic test_add();
      logic [31:0] d;
      int snap;
      snap = done_seen;
      bus_write(A_SRC, 32'h0001_007F, 4'hF);
      bus_write(A_CMD, 32'h0000_0101, 4'hF);
      n_cmp++; if (result !== 16'h0000) begin n_fail++; $display("FAIL add_before: got %h expected %h", result, 16'h0); end
      @(posedge clk); #1;
      n_cmp++; if (result !== 16'h0080) begin n_fail++; $display("FAIL add_result: got %h expected %h", result, 16'h0080); end
      n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL add_done_high: got %b expected 1", done); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_low: got %b expected 0", done); end
      bus_read(A_RESULT, d);
      n_cmp++; if (d !== 32'h0000_0080) begin n_fail++; $display("FAIL add_result_reg: got %h expected %h", d, 32'h80); end
      bus_read(A_STATUS, d);
      n_cmp++; if (d !== 32'h0001_0002) begin n_fail++; $display("FAIL add_status: got %h expected %h", d, 32'h0001_0002); end
      n_cmp++; if (done_seen - snap !== 1) begin n_fail++; $display("FAIL add_pulses: got %0d expected 1", done_seen - snap); end
      bus_write(A_STATUS, 32'h0000_0002, 4'hF);
      bus_read(A_STATUS, d);
      n_cmp++; if (d !== 32'h0001_0000) begin n_fail++; $display("FAIL done_w1c: got %h expected %h", d, 32'h0001_0000); end
   endtask

   task automatic test_mul();
      logic [31:0] d;
      int snap;
      snap = done_seen;
      bus_write(A_SRC, 32'h00FF_00FF, 4'hF);
      bus_write(A_CMD, 32'h0000_0104, 4'hF);   // edge T
      for (int k = 1; k <= 4; k++) begin
         bus_read(A_STATUS, d);                // passes edge T+k
         n_cmp++; if (d[0] !== 1'b1) begin n_fail++; $display("FAIL mul_busy_%0d: got %b expected 1", k, d[0]); end
         if (k < 4) begin
            n_cmp++; if (result !== 16'h0080) begin n_fail++; $display("FAIL mul_hold_%0d: got %h expected %h", k, result, 16'h0080); end
         end else begin
            n_cmp++; if (result !== 16'hFE01) begin n_fail++; $display("FAIL mul_result: got %h expected %h", result, 16'hFE01); end
            n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL mul_done: got %b expected 1", done); end
         end
      end
      bus_read(A_STATUS, d);
      n_cmp++; if (d !== 32'h0002_0002) begin n_fail++; $display("FAIL mul_status: got %h expected %h", d, 32'h0002_0002); end
      n_cmp++; if (done_seen - snap !== 1) begin n_fail++; $display("FAIL mul_pulses: got %0d expected 1", done_seen - snap); end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      int snap;
      snap = done_seen;
      bus_write(A_SRC, 32'h0002_0003, 4'hF);
      bus_write(A_CMD, 32'h0000_0104, 4'hF);   // E0: multiply holding executor
      for (int i = 0; i < 6; i++) begin
         bus_write(A_CMD, 32'h0000_0104, 4'hF); // E1..E6; E5 coincides with a pop
      end
      bus_read(A_STATUS, d);
      n_cmp++; if (d[2] !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", d[2]); end
      n_cmp++; if (d[12:8] !== 5'd4) begin n_fail++; $display("FAIL ovf_level: got %0d expected 4", d[12:8]); end
      bus_write(A_STATUS, 32'h0000_0004, 4'hF);
      bus_read(A_STATUS, d);
      n_cmp++; if (d[2] !== 1'b0) begin n_fail++; $display("FAIL ovf_w1c: got %b expected 0", d[2]); end
      for (int i = 0; i < 100; i++) begin
         bus_read(A_STATUS, d);
         if (d[0] == 1'b0) break;
      end
      n_cmp++; if (d !== 32'h0008_0002) begin n_fail++; $display("FAIL ovf_drain_status: got %h expected %h", d, 32'h0008_0002); end
      n_cmp++; if (done_seen - snap !== 6) begin n_fail++; $display("FAIL ovf_accepted: got %0d expected 6", done_seen - snap); end
      n_cmp++; if (result !== 16'h0006) begin n_fail++; $display("FAIL ovf_result: got %h expected %h", result, 16'h0006); end
   endtask

   task automatic test_illegal();
      logic [31:0] d;
      int snap;
      snap = done_seen;
      bus_write(A_CMD, 32'h0000_0107, 4'hF);
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL ill_done: got %b expected 0", done); end
      n_cmp++; if (result !== 16'h0006) begin n_fail++; $display("FAIL ill_result: got %h expected %h", result, 16'h0006); end
      bus_read(A_STATUS, d);
      n_cmp++; if (d !== 32'h0008_000A) begin n_fail++; $display("FAIL ill_status: got %h expected %h", d, 32'h0008_000A); end
      bus_write(A_STATUS, 32'h0000_000A, 4'hF);
      bus_read(A_STATUS, d);
      n_cmp++; if (d !== 32'h0008_0000) begin n_fail++; $display("FAIL ill_w1c: got %h expected %h", d, 32'h0008_0000); end
      bus_write(A_CMD, 32'h0000_0100, 4'hF);
      repeat (2) @(posedge clk);
      bus_read(A_STATUS, d);
      n_cmp++; if (d !== 32'h0008_0000) begin n_fail++; $display("FAIL nop_status: got %h expected %h", d, 32'h0008_0000); end
      n_cmp++; if (done_seen - snap !== 0) begin n_fail++; $display("FAIL ill_nop_pulses: got %0d expected 0", done_seen - snap); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      logic [15:0] exp_res [5];
      logic [4:0]  exp_lvl [5];
      logic        exp_dn  [5];
      int snap;
      exp_res = '{16'h0E10, 16'h00FF, 16'h0000, 16'h00FF, 16'h00FF};
      exp_lvl = '{5'd3, 5'd3, 5'd2, 5'd1, 5'd0};
      exp_dn  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      snap = done_seen;
      bus_write(A_SRC, 32'h000F_00F0, 4'hF);
      bus_write(A_CMD, 32'h0000_0104, 4'hF);   // E0: multiply 0xF0*0x0F
      bus_write(A_CMD, 32'h0000_0101, 4'hF);   // E1: ADD
      bus_write(A_CMD, 32'h0000_0102, 4'hF);   // E2: AND
      bus_write(A_CMD, 32'h0000_0103, 4'hF);   // E3: XOR
      for (int k = 0; k < 5; k++) begin
         bus_read(A_STATUS, d);                // passes edge E4+k
         n_cmp++; if (d[12:8] !== exp_lvl[k]) begin n_fail++; $display("FAIL b2b_level_%0d: got %0d expected %0d", k, d[12:8], exp_lvl[k]); end
         n_cmp++; if (result !== exp_res[k]) begin n_fail++; $display("FAIL b2b_result_%0d: got %h expected %h", k, result, exp_res[k]); end
         n_cmp++; if (done !== exp_dn[k]) begin n_fail++; $display("FAIL b2b_done_%0d: got %b expected %b", k, done, exp_dn[k]); end
      end
      n_cmp++; if (d !== 32'h000C_0002) begin n_fail++; $display("FAIL b2b_status: got %h expected %h", d, 32'h000C_0002); end
      n_cmp++; if (done_seen - snap !== 4) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 4", done_seen - snap); end
   endtask

   task automatic test_reset_mid_mul();
      logic [31:0] d;
      int snap;
      bus_write(A_SRC, 32'h0002_0003, 4'hF);
      bus_write(A_CMD, 32'h0000_0104, 4'hF);   // edge T
      repeat (2) begin @(posedge clk); #1; end
      snap = done_seen;
      reset = 1'b1;
      #1;
      n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rdata: got %h expected %h", rdata, 32'h0); end
      n_cmp++; if (result !== 16'h0) begin n_fail++; $display("FAIL rst_mid_result: got %h expected %h", result, 16'h0); end
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", done); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      n_cmp++; if (done_seen - snap !== 0) begin n_fail++; $display("FAIL rst_mid_pulses: got %0d expected 0", done_seen - snap); end
      n_cmp++; if (result !== 16'h0) begin n_fail++; $display("FAIL rst_mid_result_after: got %h expected %h", result, 16'h0); end
      bus_read(A_STATUS, d);
      n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mid_status: got %h expected %h", d, 32'h0); end
      bus_read(A_SRC, d);
      n_cmp++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mid_src: got %h expected %h", d, 32'h0); end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_bus();
      test_add();
      test_mul();
      test_overflow();
      test_illegal();
      test_back_to_back();
      test_reset_mid_mul();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "timeout");
   end

endmodule
